// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer: picks the next PC from trap,
// redirect, hold or PC+4 and drives a request/ready handshake to instruction memory.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_br_taken,
    input  logic [31:0]      i_br_target,
    input  logic             i_trap,
    input  logic [31:0]      i_trap_vec,
    input  logic             i_imem_ready,
    output logic             o_imem_req,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_nis,
    output logic             o_if_valid,
    output logic             o_misalign,
    output logic [CNT_W-1:0] o_fetch_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HOLD,
        ST_FAULT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        w_pc_nxt;
    logic [31:0]        w_pc_inc;
    logic [CNT_W-1:0]   r_fetch_cnt;
    logic               w_if_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_VECTOR;
            r_fetch_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_if_valid) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
        end
    end

    // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
    assign w_pc_inc = r_pc + 32'd4;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (r_state == ST_BOOT) begin
            w_state_nxt = ST_FETCH;
        end else if (i_trap) begin
            w_pc_nxt    = {i_trap_vec[31:2], 2'b00};
            w_state_nxt = ST_FETCH;
        end else if (r_state == ST_FAULT) begin
            w_state_nxt = ST_FAULT;
        end else if (i_br_taken && (i_br_target[1:0] != 2'b00)) begin
            w_state_nxt = ST_FAULT;
        end else if (i_br_taken) begin
            w_pc_nxt    = i_br_target;
            w_state_nxt = ST_FETCH;
        end else if (i_stall) begin
            w_state_nxt = ST_HOLD;
        end else if (r_state == ST_FETCH && i_imem_ready) begin
            w_pc_nxt = w_pc_inc;
        end else begin
            w_state_nxt = ST_FETCH;
        end
    end

    // Any redirect or stall in the same cycle squashes the returned instruction.
    assign w_if_valid  = (r_state == ST_FETCH) && i_imem_ready && !i_trap
                         && !i_br_taken && !i_stall;

    assign o_imem_req  = (r_state == ST_FETCH);
    assign o_pc        = r_pc;
    assign o_nis       = w_pc_inc;
    assign o_if_valid  = w_if_valid;
    assign o_misalign  = (r_state == ST_FAULT);
    assign o_fetch_cnt = r_fetch_cnt;

endmodule
